// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter for a register bank: two requesters share one write
// port; the winner's address/data are latched, written for one cycle, then acknowledged.
module reg_bank_write_arbiter #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WIDTH-1:0]  data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              err,
  output logic [NREGS-1:0]  wr_en,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // NREGS may equal 2**ADDR_W, so the range check needs one extra bit
  localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W + 1)'(NREGS);

  state_t              r_state;
  state_t              w_next;
  logic                r_winner;
  logic                r_last;
  logic                r_bad;
  logic [ADDR_W-1:0]   r_addr;
  logic [WIDTH-1:0]    r_data;
  logic                w_any;
  logic                w_pick1;
  logic [ADDR_W-1:0]   w_addr;
  logic [WIDTH-1:0]    w_data;

  // On a tie the requester that did not win last time is picked
  always_comb begin
    w_any   = req0 | req1;
    w_pick1 = req1 & (~req0 | ~r_last);
    w_addr  = w_pick1 ? addr1 : addr0;
    w_data  = w_pick1 ? data1 : data0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = WRITE;
      WRITE:   w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_winner <= 1'b0;
      r_last   <= 1'b1;
      r_bad    <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_winner <= w_pick1;
        r_addr   <= w_addr;
        r_data   <= w_data;
      end
      if (r_state == WRITE) begin
        r_bad <= ({1'b0, r_addr} >= LP_NREGS);
      end
      if (r_state == ACK) begin
        r_last <= r_winner;
      end
    end
  end

  // Out-of-range addresses match no decoder slot, so wr_en stays all-zero for them
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (r_state == WRITE && r_addr == ADDR_W'(i)) begin
        wr_en[i] = 1'b1;
      end
    end
    gnt0    = (r_state == ACK) & ~r_winner;
    gnt1    = (r_state == ACK) & r_winner;
    err     = (r_state == ACK) & r_bad;
    busy    = (r_state != IDLE);
    wr_data = r_data;
  end

endmodule
